imem_arbiter: RTL and testbench

Arbitrates a single-port 1024×16 instruction memory between two requesters: the CPU instruction-fetch unit (read) and the program loader (write). The block sits between those two requesters and the memory macro. It issues at most one memory access per cycle and returns fetch data with fixed one-cycle latency. It also flags out-of-range addresses so the core can trap instead of executing garbage.

---
 rtl/imem_arbiter.sv | 108 ++++++++++
 tb/tb_imem_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader writes vs CPU fetch reads, 1-cycle read latency.
// Optional fairness (bounded loader bursts) enabled by defining IMEM_ARB_FAIRNESS_EN.
module imem_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 1024,
  parameter int MAX_BURST = 4,
  localparam int MEM_AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_gnt,
  output logic              load_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic w_fetch_ok;
  logic w_load_ok;
  logic w_force_fetch;
  logic r_rd_pend;
  logic r_rd_err;
  logic r_load_err;

  assign w_fetch_ok = (fetch_addr < DEPTH_A);
  assign w_load_ok  = (load_addr < DEPTH_A);

`ifdef IMEM_ARB_FAIRNESS_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] r_burst_cnt;

  assign w_force_fetch = (r_burst_cnt == BURST_MAX) && fetch_req && load_req;

  // Counts only loader wins that made a fetch wait; any fetch win or idle fetch resets it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_burst_cnt <= '0;
    end else if (fetch_gnt || !fetch_req) begin
      r_burst_cnt <= '0;
    end else if (load_gnt && (r_burst_cnt != BURST_MAX)) begin
      r_burst_cnt <= r_burst_cnt + 1'b1;
    end
  end
`else
  assign w_force_fetch = 1'b0;
`endif

  always_comb begin
    load_gnt  = 1'b0;
    fetch_gnt = 1'b0;
    if (reset) begin
      load_gnt  = load_req && !w_force_fetch;
      fetch_gnt = fetch_req && (!load_req || w_force_fetch);
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = fetch_addr[MEM_AW-1:0];
    mem_wdata = '0;
    if (load_gnt) begin
      mem_en    = w_load_ok;
      mem_we    = w_load_ok;
      mem_addr  = load_addr[MEM_AW-1:0];
      mem_wdata = load_data;
    end else if (fetch_gnt) begin
      mem_en    = w_fetch_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_err   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_rd_pend  <= fetch_gnt;
      r_rd_err   <= fetch_gnt && !w_fetch_ok;
      r_load_err <= load_gnt && !w_load_ok;
    end
  end

  // Gating with reset drops a read that was in flight when reset arrives.
  assign fetch_rvalid = r_rd_pend && reset;
  assign fetch_err    = r_rd_err && reset;
  assign busy         = fetch_rvalid;
  assign load_err     = r_load_err && reset;
  assign fetch_rdata  = (fetch_rvalid && !r_rd_err) ? mem_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: vector table plus contention and reset-mid-read sequences.
// Checks the fairness pattern when IMEM_ARB_FAIRNESS_EN is defined.
module tb_imem_arbiter;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_gnt;
  logic        fetch_rvalid;
  logic [15:0] fetch_rdata;
  logic        fetch_err;
  logic        load_req;
  logic [15:0] load_addr;
  logic [15:0] load_data;
  logic        load_gnt;
  logic        load_err;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  imem_arbiter dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_gnt(load_gnt), .load_err(load_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory macro model: synchronous write, one-cycle registered read.
  logic [15:0] mem_model [1024];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic        freq;
    logic [15:0] faddr;
    logic        lreq;
    logic [15:0] laddr;
    logic [15:0] ldata;
    logic        fg;
    logic        lg;
    logic        en;
    logic        we;
    logic [9:0]  maddr;
    logic        rv;
    logic        fe;
    logic [15:0] rdata;
    logic        lerr;
    logic        bsy;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic rst, logic freq, logic [15:0] faddr, logic lreq,
                              logic [15:0] laddr, logic [15:0] ldata,
                              logic fg, logic lg, logic en, logic we, logic [9:0] maddr,
                              logic rv, logic fe, logic [15:0] rdata, logic lerr, logic bsy);
    vec_t v;
    v.rst = rst; v.freq = freq; v.faddr = faddr; v.lreq = lreq; v.laddr = laddr;
    v.ldata = ldata; v.fg = fg; v.lg = lg; v.en = en; v.we = we; v.maddr = maddr;
    v.rv = rv; v.fe = fe; v.rdata = rdata; v.lerr = lerr; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic freq, input logic [15:0] faddr,
                       input logic lreq, input logic [15:0] laddr, input logic [15:0] ldata);
    @(negedge clk);
    reset = rst; fetch_req = freq; fetch_addr = faddr;
    load_req = lreq; load_addr = laddr; load_data = ldata;
    #1;
  endtask

  initial begin
    // rows: rst freq faddr lreq laddr ldata | fg lg en we maddr | rv fe rdata lerr busy
    vecs[0]  = mk(0, 1, 16'h0005, 1, 16'h0007, 16'h1234, 0, 0, 0, 0, 10'h000, 0, 0, 16'h0000, 0, 0);
    vecs[1]  = mk(0, 1, 16'h0005, 1, 16'h0007, 16'h1234, 0, 0, 0, 0, 10'h000, 0, 0, 16'h0000, 0, 0);
    vecs[2]  = mk(0, 1, 16'h0005, 1, 16'h0007, 16'h1234, 0, 0, 0, 0, 10'h000, 0, 0, 16'h0000, 0, 0);
    vecs[3]  = mk(1, 1, 16'h0000, 1, 16'h0000, 16'hF00F, 0, 1, 1, 1, 10'h000, 0, 0, 16'h0000, 0, 0);
    vecs[4]  = mk(1, 1, 16'h0000, 1, 16'h0001, 16'h1A2B, 0, 1, 1, 1, 10'h001, 0, 0, 16'h0000, 0, 0);
    vecs[5]  = mk(1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 10'h000, 0, 0, 16'h0000, 0, 0);
    vecs[6]  = mk(1, 1, 16'h0001, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 10'h001, 1, 0, 16'hF00F, 0, 1);
    vecs[7]  = mk(1, 1, 16'h0400, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 10'h000, 1, 0, 16'h1A2B, 0, 1);
    vecs[8]  = mk(1, 0, 16'h0000, 1, 16'hFFFF, 16'hBEEF, 0, 1, 0, 0, 10'h000, 1, 1, 16'h0000, 0, 1);
    vecs[9]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 10'h000, 0, 0, 16'h0000, 1, 0);
    vecs[10] = mk(1, 0, 16'h0000, 1, 16'h03FF, 16'h5A5A, 0, 1, 1, 1, 10'h3FF, 0, 0, 16'h0000, 0, 0);
    vecs[11] = mk(1, 1, 16'h03FF, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 10'h3FF, 0, 0, 16'h0000, 0, 0);
    vecs[12] = mk(1, 1, 16'h8001, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 10'h000, 1, 0, 16'h5A5A, 0, 1);
    vecs[13] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 10'h000, 1, 1, 16'h0000, 0, 1);
    vecs[14] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 10'h000, 0, 0, 16'h0000, 0, 0);

    reset = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    load_req = 1'b0; load_addr = '0; load_data = '0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst, vecs[i].freq, vecs[i].faddr, vecs[i].lreq, vecs[i].laddr, vecs[i].ldata);
      chk($sformatf("v%0d fetch_gnt", i), 32'(fetch_gnt), 32'(vecs[i].fg));
      chk($sformatf("v%0d load_gnt", i), 32'(load_gnt), 32'(vecs[i].lg));
      chk($sformatf("v%0d mem_en", i), 32'(mem_en), 32'(vecs[i].en));
      chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].we));
      if (vecs[i].en) begin
        chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
        if (vecs[i].we) chk($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].ldata));
      end
      chk($sformatf("v%0d fetch_rvalid", i), 32'(fetch_rvalid), 32'(vecs[i].rv));
      chk($sformatf("v%0d fetch_err", i), 32'(fetch_err), 32'(vecs[i].fe));
      chk($sformatf("v%0d fetch_rdata", i), 32'(fetch_rdata), 32'(vecs[i].rdata));
      chk($sformatf("v%0d load_err", i), 32'(load_err), 32'(vecs[i].lerr));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
    end

    // Sustained contention: strict loader priority, or L,L,L,L,F with fairness.
    for (int c = 0; c < 10; c++) begin
      logic exp_f;
`ifdef IMEM_ARB_FAIRNESS_EN
      exp_f = ((c % 5) == 4);
`else
      exp_f = 1'b0;
`endif
      drive(1, 1, 16'h0010, 1, 16'h0010, 16'h0C0C);
      chk($sformatf("contend%0d fetch_gnt", c), 32'(fetch_gnt), 32'(exp_f));
      chk($sformatf("contend%0d load_gnt", c), 32'(load_gnt), 32'(!exp_f));
    end
    drive(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    drive(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    chk("idle rvalid", 32'(fetch_rvalid), 32'd0);

    // Reset arriving while a read is in flight.
    drive(1, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    chk("rmr grant", 32'(fetch_gnt), 32'd1);
    chk("rmr mem_en", 32'(mem_en), 32'd1);
    drive(0, 1, 16'h0000, 1, 16'h0002, 16'h7777);
    chk("rmr rvalid in reset", 32'(fetch_rvalid), 32'd0);
    chk("rmr busy in reset", 32'(busy), 32'd0);
    chk("rmr rdata in reset", 32'(fetch_rdata), 32'd0);
    chk("rmr no gnt in reset", 32'({fetch_gnt, load_gnt, mem_en, mem_we}), 32'd0);
    drive(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    chk("rmr rvalid after", 32'(fetch_rvalid), 32'd0);
    chk("rmr rdata after", 32'(fetch_rdata), 32'd0);
    drive(1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    chk("rmr rvalid later", 32'(fetch_rvalid), 32'd0);
    chk("rmr busy later", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
